// File: rtl/drink_chute_arb.sv
// ============================================================================
// Module      : drink_chute_arb
// Description : Round-robin arbiter/sequencer for a shared drink chute.
//               Optional jam fault handling enabled by DRINK_ARB_JAM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drink_chute_arb #(
    parameter int N_REQ    = 4,
    parameter int DISP_CYC = 8,
    parameter int GAP_CYC  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic                       jam,
    input  logic                       fault_clr,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic                       chute_on,
    output logic [$clog2(N_REQ)-1:0]   chute_id,
    output logic                       busy,
    output logic                       fault
);

    localparam int                IDW         = $clog2(N_REQ);
    localparam logic [IDW:0]      c_nreq      = (IDW+1)'(N_REQ);
    localparam logic [IDW-1:0]    c_last_init = IDW'(N_REQ-1);
    localparam logic [7:0]        c_disp_last = 8'(DISP_CYC-1);
    localparam logic [7:0]        c_gap_last  = 8'(GAP_CYC-1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_DISP  = 3'd2,
`ifdef DRINK_ARB_JAM_EN
        ST_GAP   = 3'd3,
        ST_FAULT = 3'd4
`else
        ST_GAP   = 3'd3
`endif
    } state_t;

    state_t             r_state,    w_state_n;
    logic [7:0]         r_cnt,      w_cnt_n;
    logic [IDW-1:0]     r_last,     w_last_n;
    logic [IDW-1:0]     r_chute_id, w_chute_id_n;
    logic [N_REQ-1:0]   r_gnt,      w_gnt_n;
    logic [N_REQ-1:0]   r_done,     w_done_n;
    logic               r_chute_on, w_chute_on_n;
    logic               r_busy,     w_busy_n;
    logic               r_fault,    w_fault_n;

    logic               w_found;
    logic [IDW-1:0]     w_pick;
    logic [IDW:0]       w_sum;

    // Scan upward from the last winner, wrapping, and take the first request.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_sum = {1'b0, r_last} + (IDW+1)'(i);
            if (w_sum >= c_nreq) begin
                w_sum = w_sum - c_nreq;
            end
            if (!w_found && req[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_last_n     = r_last;
        w_chute_id_n = r_chute_id;
        w_gnt_n      = '0;
        w_done_n     = '0;
        w_chute_on_n = r_chute_on;
        w_busy_n     = r_busy;
        w_fault_n    = r_fault;

        case (r_state)
            ST_IDLE: begin
                w_chute_on_n = 1'b0;
                w_busy_n     = 1'b0;
                if (w_found) begin
                    w_state_n        = ST_GRANT;
                    w_chute_id_n     = w_pick;
                    w_last_n         = w_pick;
                    w_gnt_n[w_pick]  = 1'b1;
                    w_busy_n         = 1'b1;
                end
            end
            ST_GRANT: begin
                w_state_n    = ST_DISP;
                w_chute_on_n = 1'b1;
                w_cnt_n      = 8'd0;
            end
            ST_DISP: begin
`ifdef DRINK_ARB_JAM_EN
                if (jam) begin
                    w_state_n    = ST_FAULT;
                    w_chute_on_n = 1'b0;
                    w_fault_n    = 1'b1;
                    w_cnt_n      = 8'd0;
                end else
`endif
                if (r_cnt == c_disp_last) begin
                    w_state_n              = ST_GAP;
                    w_chute_on_n           = 1'b0;
                    w_done_n[r_chute_id]   = 1'b1;
                    w_cnt_n                = 8'd0;
                end else begin
                    w_cnt_n = r_cnt + 8'd1;
                end
            end
            ST_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_state_n = ST_IDLE;
                    w_busy_n  = 1'b0;
                    w_cnt_n   = 8'd0;
                end else begin
                    w_cnt_n = r_cnt + 8'd1;
                end
            end
`ifdef DRINK_ARB_JAM_EN
            ST_FAULT: begin
                if (fault_clr) begin
                    w_state_n = ST_IDLE;
                    w_fault_n = 1'b0;
                    w_busy_n  = 1'b0;
                end
            end
`endif
            default: begin
                w_state_n    = ST_IDLE;
                w_chute_on_n = 1'b0;
                w_busy_n     = 1'b0;
                w_fault_n    = 1'b0;
                w_cnt_n      = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_last     <= c_last_init;
            r_chute_id <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_chute_on <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_last     <= w_last_n;
            r_chute_id <= w_chute_id_n;
            r_gnt      <= w_gnt_n;
            r_done     <= w_done_n;
            r_chute_on <= w_chute_on_n;
            r_busy     <= w_busy_n;
        end
    end

`ifdef DRINK_ARB_JAM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_n;
        end
    end
`else
    // Jam inputs have no effect in this build; fault can never latch.
    logic w_unused_inputs;
    assign w_unused_inputs = jam ^ fault_clr ^ w_fault_n;
    assign r_fault         = 1'b0;
`endif

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign chute_on = r_chute_on;
    assign chute_id = r_chute_id;
    assign busy     = r_busy;
    assign fault    = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_drink_chute_arb.sv
// ============================================================================
// Module      : tb_drink_chute_arb
// Description : Self-checking bench for drink_chute_arb (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_drink_chute_arb;

    localparam int N = 4;
    localparam int D = 8;
    localparam int G = 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         jam;
    logic         fault_clr;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         chute_on;
    logic [1:0]   chute_id;
    logic         busy;
    logic         fault;

    int n_checks = 0;
    int n_fail   = 0;

    drink_chute_arb #(.N_REQ(N), .DISP_CYC(D), .GAP_CYC(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .jam       (jam),
        .fault_clr (fault_clr),
        .gnt       (gnt),
        .done      (done),
        .chute_on  (chute_on),
        .chute_id  (chute_id),
        .busy      (busy),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        jam       = 1'b0;
        fault_clr = 1'b0;
        tick();
        rst_n     = 1'b1;
    endtask

    function automatic int rr_pick(int last_idx, logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            if (r[(last_idx + i) % N]) return (last_idx + i) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; req = '0; jam = 1'b0; fault_clr = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (gnt !== 4'b0000)  begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b want 0000", done); end
        n_checks++; if ({chute_on, busy, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {chute_on, busy, fault}); end
        n_checks++; if (chute_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", chute_id); end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        tick();
        req = '0;
        n_checks++; if (gnt !== 4'b0100 || busy !== 1'b1 || chute_on !== 1'b0) begin n_fail++; $display("FAIL single_grant: got gnt=%b busy=%b on=%b want 0100 1 0", gnt, busy, chute_on); end
        for (int e = 1; e <= D; e++) begin
            tick();
            n_checks++; if (chute_on !== 1'b1 || chute_id !== 2'd2 || gnt !== 4'b0 || done !== 4'b0) begin n_fail++; $display("FAIL single_disp e%0d: got on=%b id=%0d gnt=%b done=%b want 1 2 0000 0000", e, chute_on, chute_id, gnt, done); end
        end
        tick();
        n_checks++; if (done !== 4'b0100 || chute_on !== 1'b0) begin n_fail++; $display("FAIL single_done: got done=%b on=%b want 0100 0", done, chute_on); end
        tick();
        n_checks++; if (busy !== 1'b1 || done !== 4'b0) begin n_fail++; $display("FAIL single_gap: got busy=%b done=%b want 1 0000", busy, done); end
        tick();
        n_checks++; if (busy !== 1'b0 || chute_id !== 2'd2) begin n_fail++; $display("FAIL single_idle: got busy=%b id=%0d want 0 2", busy, chute_id); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            tick();
            n_checks++; if (gnt !== 4'(1 << k)) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, gnt, 4'(1 << k)); end
            req[k] = 1'b0;
            for (int e = 1; e <= D + G + 1; e++) begin
                tick();
                if (e == D + 1) begin
                    n_checks++; if (done !== 4'(1 << k)) begin n_fail++; $display("FAIL rr_done%0d: got %b want %b", k, done, 4'(1 << k)); end
                end
                if (e == D + G + 1) begin
                    n_checks++; if (busy !== 1'b0 || gnt !== 4'b0) begin n_fail++; $display("FAIL rr_idle%0d: got busy=%b gnt=%b want 0 0000", k, busy, gnt); end
                end
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req = 4'b0010;
        tick();
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL fair_first: got %b want 0010", gnt); end
        req = 4'b0101;
        for (int e = 1; e <= D + G + 1; e++) tick();
        tick();
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL fair_second: got %b want 0100", gnt); end
        req = 4'b0001;
        for (int e = 1; e <= D + G + 1; e++) tick();
        tick();
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL fair_third: got %b want 0001", gnt); end
        req = '0;
        for (int e = 1; e <= D + G + 1; e++) tick();
    endtask

    task automatic test_reset_in_disp();
        do_reset();
        req = 4'b0010;
        tick();
        req = '0;
        for (int e = 1; e <= 5; e++) tick();
        n_checks++; if (chute_on !== 1'b1) begin n_fail++; $display("FAIL abort_pre: got on=%b want 1", chute_on); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({gnt, done, chute_on, chute_id, busy, fault} !== 13'd0) begin n_fail++; $display("FAIL abort_async: got %h want 0", {gnt, done, chute_on, chute_id, busy, fault}); end
        for (int e = 0; e < 5; e++) begin
            tick();
            n_checks++; if (done !== 4'b0 || chute_on !== 1'b0) begin n_fail++; $display("FAIL abort_hold: got done=%b on=%b want 0000 0", done, chute_on); end
        end
        rst_n = 1'b1;
        req = 4'b1001;
        tick();
        n_checks++; if (gnt !== 4'b0001 || chute_id !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_regrant: got gnt=%b id=%0d busy=%b want 0001 0 1", gnt, chute_id, busy); end
        req = '0;
        for (int e = 1; e <= D + G + 1; e++) tick();
    endtask

    task automatic test_gap_pulse();
        do_reset();
        req = 4'b0001;
        tick();
        req = '0;
        for (int e = 1; e <= D + 1; e++) tick();
        req = 4'b1000;
        tick();
        n_checks++; if (busy !== 1'b1 || gnt !== 4'b0) begin n_fail++; $display("FAIL gap_busy: got busy=%b gnt=%b want 1 0000", busy, gnt); end
        tick();
        n_checks++; if (busy !== 1'b0 || gnt !== 4'b0) begin n_fail++; $display("FAIL gap_end: got busy=%b gnt=%b want 0 0000", busy, gnt); end
        req = '0;
        for (int e = 0; e < 3; e++) begin
            tick();
            n_checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL gap_nogrant: got gnt=%b busy=%b want 0000 0", gnt, busy); end
        end
    endtask

    task automatic test_jam();
        do_reset();
        req = 4'b0001;
        tick();
        req = '0;
        for (int e = 1; e <= 4; e++) tick();
`ifdef DRINK_ARB_JAM_EN
        jam = 1'b1;
        tick();
        n_checks++; if (chute_on !== 1'b0 || fault !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL jam_fault: got on=%b fault=%b busy=%b want 0 1 1", chute_on, fault, busy); end
        jam = 1'b0;
        req = 4'b0010;
        for (int e = 0; e < 6; e++) begin
            tick();
            n_checks++; if (gnt !== 4'b0 || done !== 4'b0 || fault !== 1'b1) begin n_fail++; $display("FAIL jam_hold: got gnt=%b done=%b fault=%b want 0000 0000 1", gnt, done, fault); end
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_checks++; if (fault !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL jam_clear: got fault=%b busy=%b want 0 0", fault, busy); end
        tick();
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL jam_regrant: got %b want 0010", gnt); end
        req = '0;
        for (int e = 1; e <= D + G + 1; e++) tick();
`else
        jam = 1'b1;
        fault_clr = 1'b1;
        for (int e = 5; e <= D; e++) begin
            tick();
            n_checks++; if (chute_on !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL nojam_disp e%0d: got on=%b fault=%b want 1 0", e, chute_on, fault); end
        end
        tick();
        n_checks++; if (done !== 4'b0001 || fault !== 1'b0) begin n_fail++; $display("FAIL nojam_done: got done=%b fault=%b want 0001 0", done, fault); end
        jam = 1'b0;
        fault_clr = 1'b0;
        for (int e = 0; e < G; e++) tick();
`endif
    endtask

    // Reference model: a grant opens a fixed timeline of D+G+2 cycles.
    task automatic test_random();
        int           m_last;
        int           m_id;
        int           m_phase;
        logic [N-1:0] r_now;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_done;
        logic         e_on;
        logic         e_busy;
        do_reset();
        m_last  = N - 1;
        m_id    = 0;
        m_phase = -1;
        for (int cyc = 0; cyc < 800; cyc++) begin
`ifndef DRINK_ARB_JAM_EN
            jam       = 1'($urandom_range(0, 1));
            fault_clr = 1'($urandom_range(0, 1));
`endif
            r_now = req;
            tick();
            if (m_phase < 0) begin
                if (r_now != '0) begin
                    m_id    = rr_pick(m_last, r_now);
                    m_last  = m_id;
                    m_phase = 0;
                end
            end else begin
                m_phase++;
                if (m_phase == D + G + 1) m_phase = -1;
            end
            e_gnt  = (m_phase == 0)     ? 4'(1 << m_id) : 4'b0;
            e_done = (m_phase == D + 1) ? 4'(1 << m_id) : 4'b0;
            e_on   = (m_phase >= 1 && m_phase <= D);
            e_busy = (m_phase >= 0);
            n_checks++;
            if ({gnt, done, chute_on, busy, chute_id, fault} !== {e_gnt, e_done, e_on, e_busy, 2'(m_id), 1'b0}) begin
                n_fail++;
                $display("FAIL random cyc%0d: got gnt=%b done=%b on=%b busy=%b id=%0d fault=%b want %b %b %b %b %0d 0",
                         cyc, gnt, done, chute_on, busy, chute_id, fault, e_gnt, e_done, e_on, e_busy, m_id);
            end
            req = req & ~gnt;
            if ($urandom_range(0, 5) == 0) req = req | 4'($urandom);
        end
        req = '0;
        jam = 1'b0;
        fault_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_reset_in_disp();
        test_gap_pulse();
        test_jam();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
